// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: tracks the destinations of in-flight instructions,
// picks forwarding sources for the two decode operands, raises load-use stalls,
// generates the front-end flush window after a redirect and counts stall cycles.

// One operand lane: finds the youngest in-flight producer of src and reports
// whether that producer is a load whose data is not yet forwardable.
module phc_src_fwd #(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2,
  parameter int SEL_W      = 2
) (
  input  logic [REG_AW-1:0]            src,
  input  logic                         use_src,
  input  logic [DEPTH:1]               vld,
  input  logic [DEPTH:1]               we,
  input  logic [DEPTH:1]               ld,
  input  logic [DEPTH:1][REG_AW-1:0]   dst,
  output logic [SEL_W-1:0]             sel,
  output logic                         ld_hz
);

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    sel   = '0;
    ld_hz = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (use_src && (src != '0) && vld[k] && we[k] && (dst[k] == src)) begin
        sel   = SEL_W'(k);
        ld_hz = ld[k] && (k < LOAD_READY);
      end
    end
  end

endmodule

module pipe_hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2,
  parameter int FLUSH_LEN  = 1,
  parameter int SEL_W      = $clog2(DEPTH+1)
) (
  input  logic              in_CLK,
  input  logic              in_RST_N,
  input  logic              in_IV,
  input  logic [REG_AW-1:0] in_RS,
  input  logic [REG_AW-1:0] in_RT,
  input  logic              in_USE_RS,
  input  logic              in_USE_RT,
  input  logic [REG_AW-1:0] in_DST,
  input  logic              in_WE,
  input  logic              in_LD,
  input  logic              in_REDIRECT,
  input  logic              in_CLRCNT,
  output logic [SEL_W-1:0]  out_FWD_RS,
  output logic [SEL_W-1:0]  out_FWD_RT,
  output logic              out_STALL,
  output logic              out_PCEN,
  output logic              out_FDEN,
  output logic              out_FLUSH,
  output logic [15:0]       out_STALLCNT
);

  localparam logic [1:0] FL_LOAD = 2'(FLUSH_LEN-1);

  // entry k mirrors the instruction sitting in post-decode stage k
  logic [DEPTH:1]             vld_pipe;
  logic [DEPTH:1]             we_pipe;
  logic [DEPTH:1]             ld_pipe;
  logic [DEPTH:1][REG_AW-1:0] dst_pipe;

  logic [1:0]                 fl_cnt;
  logic [15:0]                stall_cnt;

  logic [1:0][REG_AW-1:0]     src_v;
  logic [1:0]                 use_v;
  logic [1:0][SEL_W-1:0]      sel_v;
  logic [1:0]                 hz_v;
  logic                       issue;

  assign src_v = {in_RT, in_RS};
  assign use_v = {in_USE_RT, in_USE_RS};

  for (genvar s = 0; s < 2; s++) begin : g_src
    phc_src_fwd #(
      .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .SEL_W(SEL_W)
    ) u_fwd (
      .src(src_v[s]), .use_src(use_v[s]),
      .vld(vld_pipe), .we(we_pipe), .ld(ld_pipe), .dst(dst_pipe),
      .sel(sel_v[s]), .ld_hz(hz_v[s])
    );
  end

  assign out_FWD_RS   = sel_v[0];
  assign out_FWD_RT   = sel_v[1];
  // flush takes priority over a load-use hazard: the consumer is being discarded anyway
  assign out_FLUSH    = in_REDIRECT | (fl_cnt != 2'd0);
  assign out_STALL    = in_IV & ~out_FLUSH & (|hz_v);
  assign out_PCEN     = ~out_STALL;
  assign out_FDEN     = ~out_STALL;
  assign out_STALLCNT = stall_cnt;
  assign issue        = in_IV & ~out_STALL & ~out_FLUSH;

  // Tracking entries: stage 1 takes the decode instruction or a bubble, the rest shift.
  always_ff @(posedge in_CLK or negedge in_RST_N) begin
    if (!in_RST_N) begin
      vld_pipe <= '0;
      we_pipe  <= '0;
      ld_pipe  <= '0;
      dst_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[DEPTH-1:1], issue};
      we_pipe  <= {we_pipe[DEPTH-1:1],  in_WE};
      ld_pipe  <= {ld_pipe[DEPTH-1:1],  in_LD};
      dst_pipe <= {dst_pipe[DEPTH-1:1], in_DST};
    end
  end

  // Flush window: a redirect (re)loads the remaining-cycle count.
  always_ff @(posedge in_CLK or negedge in_RST_N) begin
    if (!in_RST_N)               fl_cnt <= 2'd0;
    else if (in_REDIRECT)        fl_cnt <= FL_LOAD;
    else if (fl_cnt != 2'd0)     fl_cnt <= fl_cnt - 2'd1;
  end

  // Saturating stall-cycle counter; clear beats increment.
  always_ff @(posedge in_CLK or negedge in_RST_N) begin
    if (!in_RST_N)                              stall_cnt <= 16'd0;
    else if (in_CLRCNT)                         stall_cnt <= 16'd0;
    else if (out_STALL && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three configurations share one stimulus stream;
// each has a reference model of in-flight instructions checked every cycle,
// plus directed literal checks on the scenarios of interest.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

  typedef struct packed {bit v; bit [4:0] dst; bit we; bit ld;} ent_t;
  typedef ent_t [8:1] pipe_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       iv = 0, use_rs = 0, use_rt = 0, we = 0, ld = 0, redirect = 0, clrcnt = 0;
  logic [4:0] rs = 0, rt = 0, dst = 0;

  logic [1:0] a_frs, a_frt;  logic a_stall, a_pcen, a_fden, a_flush; logic [15:0] a_cnt;
  logic [2:0] b_frs, b_frt;  logic b_stall, b_pcen, b_fden, b_flush; logic [15:0] b_cnt;
  logic [3:0] c_frs, c_frt;  logic c_stall, c_pcen, c_fden, c_flush; logic [15:0] c_cnt;

  pipe_hazard_ctrl u_a (
    .in_CLK(clk), .in_RST_N(rst_n), .in_IV(iv), .in_RS(rs), .in_RT(rt),
    .in_USE_RS(use_rs), .in_USE_RT(use_rt), .in_DST(dst), .in_WE(we), .in_LD(ld),
    .in_REDIRECT(redirect), .in_CLRCNT(clrcnt), .out_FWD_RS(a_frs), .out_FWD_RT(a_frt),
    .out_STALL(a_stall), .out_PCEN(a_pcen), .out_FDEN(a_fden), .out_FLUSH(a_flush),
    .out_STALLCNT(a_cnt));

  pipe_hazard_ctrl #(.DEPTH(5), .LOAD_READY(4), .FLUSH_LEN(3)) u_b (
    .in_CLK(clk), .in_RST_N(rst_n), .in_IV(iv), .in_RS(rs), .in_RT(rt),
    .in_USE_RS(use_rs), .in_USE_RT(use_rt), .in_DST(dst), .in_WE(we), .in_LD(ld),
    .in_REDIRECT(redirect), .in_CLRCNT(clrcnt), .out_FWD_RS(b_frs), .out_FWD_RT(b_frt),
    .out_STALL(b_stall), .out_PCEN(b_pcen), .out_FDEN(b_fden), .out_FLUSH(b_flush),
    .out_STALLCNT(b_cnt));

  pipe_hazard_ctrl #(.DEPTH(8), .LOAD_READY(8)) u_c (
    .in_CLK(clk), .in_RST_N(rst_n), .in_IV(iv), .in_RS(rs), .in_RT(rt),
    .in_USE_RS(use_rs), .in_USE_RT(use_rt), .in_DST(dst), .in_WE(we), .in_LD(ld),
    .in_REDIRECT(redirect), .in_CLRCNT(clrcnt), .out_FWD_RS(c_frs), .out_FWD_RT(c_frt),
    .out_STALL(c_stall), .out_PCEN(c_pcen), .out_FDEN(c_fden), .out_FLUSH(c_flush),
    .out_STALLCNT(c_cnt));

  int n_chk = 0, n_fail = 0;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  pipe_t ma = '0, mb = '0, mc = '0;
  int    fa = 0, fb = 0, fc = 0;      // flush cycles still owed after this one
  int    ca = 0, cb = 0, cc = 0;      // stall cycle counts

  // Outputs follow from who is in flight: youngest writer of each source,
  // and whether that writer's load data is still too young to forward.
  function automatic void eval(input pipe_t p, input int depth, input int lr, input int frem,
                               output int frs, output int frt, output bit stl, output bit fl);
    bit hz = 0;
    fl  = redirect || (frem > 0);
    frs = 0; frt = 0;
    for (int k = 1; k <= depth; k++) begin
      if (frs == 0 && use_rs && rs != 0 && p[k].v && p[k].we && p[k].dst == rs) begin
        frs = k; if (p[k].ld && k < lr) hz = 1;
      end
      if (frt == 0 && use_rt && rt != 0 && p[k].v && p[k].we && p[k].dst == rt) begin
        frt = k; if (p[k].ld && k < lr) hz = 1;
      end
    end
    stl = iv && !fl && hz;
  endfunction

  task automatic adv(input pipe_t p, input int depth, input int lr, input int flen,
                     input int frem, input int cnt,
                     output pipe_t q, output int nfrem, output int ncnt);
    int frs, frt; bit stl, fl;
    eval(p, depth, lr, frem, frs, frt, stl, fl);
    q = p;
    for (int k = depth; k >= 2; k--) q[k] = p[k-1];
    q[1] = '{v: iv && !stl && !fl, dst: dst, we: we, ld: ld};
    nfrem = redirect ? flen-1 : (frem > 0 ? frem-1 : 0);
    ncnt  = clrcnt ? 0 : ((stl && cnt < 65535) ? cnt+1 : cnt);
  endtask

  always @(posedge clk or negedge rst_n) begin : mdl
    pipe_t na, nb, nc;
    int    nfa, nfb, nfc, nca, ncb, ncc;
    if (!rst_n) begin
      ma <= '0; mb <= '0; mc <= '0;
      fa <= 0;  fb <= 0;  fc <= 0;
      ca <= 0;  cb <= 0;  cc <= 0;
    end else begin
      adv(ma, 3, 2, 1, fa, ca, na, nfa, nca);
      adv(mb, 5, 4, 3, fb, cb, nb, nfb, ncb);
      adv(mc, 8, 8, 1, fc, cc, nc, nfc, ncc);
      ma <= na; fa <= nfa; ca <= nca;
      mb <= nb; fb <= nfb; cb <= ncb;
      mc <= nc; fc <= nfc; cc <= ncc;
    end
  end

  task automatic cmp(string id, input pipe_t p, input int depth, input int lr, input int frem,
                     input int cnt, input int frs_a, input int frt_a, input int stl_a,
                     input int pcen_a, input int fden_a, input int fl_a, input int cnt_a);
    int frs, frt; bit stl, fl;
    eval(p, depth, lr, frem, frs, frt, stl, fl);
    chk({id, "_fwd_rs"}, frs_a, frs);
    chk({id, "_fwd_rt"}, frt_a, frt);
    chk({id, "_stall"},  stl_a, int'(stl));
    chk({id, "_pcen"},   pcen_a, int'(!stl));
    chk({id, "_fden"},   fden_a, int'(!stl));
    chk({id, "_flush"},  fl_a, int'(fl));
    chk({id, "_cnt"},    cnt_a, cnt);
  endtask

  always @(negedge clk) begin
    cmp("a", ma, 3, 2, fa, ca, a_frs, a_frt, a_stall, a_pcen, a_fden, a_flush, a_cnt);
    cmp("b", mb, 5, 4, fb, cb, b_frs, b_frt, b_stall, b_pcen, b_fden, b_flush, b_cnt);
    cmp("c", mc, 8, 8, fc, cc, c_frs, c_frt, c_stall, c_pcen, c_fden, c_flush, c_cnt);
  end

  // ---------------- stimulus ----------------
  task automatic put(bit v, int s1, bit u1, int s2, bit u2, int d, bit w, bit l);
    iv = v; rs = 5'(s1); use_rs = u1; rt = 5'(s2); use_rt = u2;
    dst = 5'(d); we = w; ld = l;
  endtask

  task automatic nop();
    put(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cyc(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int    t1, t2, nst;
  bit    ts, tf;

  initial begin
    // reset: quiet outputs, flush follows redirect directly
    redirect = 1; #2;
    chk("rst_flush_follows_redirect", a_flush, 1);
    chk("rst_stall", a_stall, 0);
    chk("rst_pcen", a_pcen, 1);
    chk("rst_fden", a_fden, 1);
    chk("rst_fwd_rs", a_frs, 0);
    chk("rst_cnt", a_cnt, 0);
    redirect = 0; #1;
    chk("rst_flush_low", a_flush, 0);
    @(posedge clk); #3 rst_n = 1;
    cyc(1);

    // ALU producer then dependents at gap 0 and gap 1
    put(1, 0, 0, 0, 0, 3, 1, 0); cyc(1);
    put(1, 3, 1, 0, 0, 4, 1, 0); #1;
    chk("alu_gap0_fwd_rs", a_frs, 1);
    chk("alu_gap0_stall", a_stall, 0);
    cyc(1);
    put(1, 3, 1, 0, 0, 0, 0, 0); #1;
    chk("alu_gap1_fwd_rs", a_frs, 2);
    cyc(1); nop(); cyc(8);

    // load-use: one stall cycle, then forward from stage 2
    put(1, 0, 0, 0, 0, 5, 1, 1); cyc(1);
    put(1, 0, 0, 5, 1, 6, 1, 0); #1;
    chk("lu_stall", a_stall, 1);
    chk("lu_pcen", a_pcen, 0);
    chk("lu_fden", a_fden, 0);
    chk("lu_fwd_rt_during_stall", a_frt, 1);
    cyc(1); #1;
    chk("lu_cnt", a_cnt, 1);
    chk("lu_stall_released", a_stall, 0);
    chk("lu_fwd_rt", a_frt, 2);
    cyc(1); nop(); cyc(8);

    // youngest producer wins; r0 never forwards; use flag gates matching
    put(1, 0, 0, 0, 0, 7, 1, 0); cyc(1);
    put(1, 0, 0, 0, 0, 9, 1, 0); cyc(1);
    put(1, 0, 0, 0, 0, 7, 1, 0); cyc(1);
    put(1, 7, 1, 7, 1, 0, 0, 0); #1;
    chk("youngest_fwd_rs", a_frs, 1);
    chk("youngest_fwd_rt", a_frt, 1);
    chk("youngest_b_fwd_rs", b_frs, 1);
    cyc(1);
    put(1, 0, 0, 0, 0, 0, 1, 0); cyc(1);
    put(1, 0, 1, 0, 1, 0, 0, 0); #1;
    chk("r0_fwd_rs", a_frs, 0);
    chk("r0_fwd_rt", a_frt, 0);
    put(1, 7, 0, 0, 0, 0, 0, 0); #1;
    chk("nouse_fwd_rs", a_frs, 0);
    put(1, 7, 1, 0, 0, 0, 0, 0); #1;
    chk("older_r7_fwd_rs", a_frs, 3);
    cyc(1); nop(); cyc(8);

    // redirect on top of a load-use: flush wins, stage 1 takes a bubble
    put(1, 0, 0, 0, 0, 5, 1, 1); cyc(1);
    put(1, 0, 0, 5, 1, 5, 1, 0); redirect = 1; #1;
    chk("rd_lu_flush", a_flush, 1);
    chk("rd_lu_stall", a_stall, 0);
    chk("rd_lu_pcen", a_pcen, 1);
    chk("rd_lu_fwd_rt", a_frt, 1);
    cyc(1); redirect = 0; #1;
    chk("rd_lu_flush_done", a_flush, 0);
    chk("rd_lu_bubble_fwd_rt", a_frt, 2);
    chk("rd_lu_after_stall", a_stall, 0);
    chk("rd_lu_b_flush_tail", b_flush, 1);
    cyc(1); nop(); cyc(8);

    // FLUSH_LEN=3 window, restarted by a second redirect in cycle 2
    redirect = 1; #1; chk("fl3_c0", b_flush, 1);
    cyc(1); redirect = 0; #1; chk("fl3_c1", b_flush, 1); chk("fl1_a_c1", a_flush, 0);
    cyc(1); redirect = 1; #1; chk("fl3_c2", b_flush, 1);
    cyc(1); redirect = 0; #1; chk("fl3_c3", b_flush, 1);
    cyc(1); #1; chk("fl3_c4", b_flush, 1);
    cyc(1); #1; chk("fl3_c5", b_flush, 0);
    cyc(8);

    // asynchronous reset in the middle of a stall
    put(1, 0, 0, 0, 0, 5, 1, 1); cyc(1);
    put(1, 0, 0, 5, 1, 6, 1, 0); #1;
    chk("ar_pre_stall", a_stall, 1);
    rst_n = 0; #1;
    chk("ar_stall", a_stall, 0);
    chk("ar_fwd_rt", a_frt, 0);
    chk("ar_pcen", a_pcen, 1);
    chk("ar_cnt", a_cnt, 0);
    rst_n = 1;
    cyc(1); #1;
    chk("ar_post_stall", a_stall, 0);
    chk("ar_post_fwd_rt", a_frt, 0);
    nop(); cyc(8);

    // DEPTH=5, LOAD_READY=4: load-use stalls three cycles
    put(1, 0, 0, 0, 0, 5, 1, 1); cyc(1);
    put(1, 0, 0, 5, 1, 6, 1, 0);
    nst = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (!b_stall) break;
      nst++;
      cyc(1);
    end
    chk("b_lu_stall_cycles", nst, 3);
    chk("b_lu_fwd_rt", b_frt, 4);
    cyc(1); nop(); cyc(8);

    // saturation: self-dependent load keeps DEPTH=8 stalling 7 of every 8 cycles
    put(1, 5, 1, 0, 0, 5, 1, 1);
    cyc(75000);
    chk("sat_cnt", c_cnt, 65535);
    for (int i = 0; i < 10; i++) begin
      eval(mc, 8, 8, fc, t1, t2, ts, tf);
      if (ts) break;
      cyc(1);
    end
    clrcnt = 1; #1;
    chk("clr_same_cycle_stall", c_stall, 1);
    cyc(1); clrcnt = 0; #1;
    chk("clr_wins", c_cnt, 0);
    nop(); cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
